// File: rtl/gx4000_rs232_uart_if.sv
// CPU-side byte/strobe/status bundle between the RS232 I/O register block and
// the serial line engine.
interface gx4000_rs232_uart_if;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy;
    logic       tx_overflow;
    logic       tx_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       rx_overrun;
    logic       rx_frame_err;

    modport master (
        output tx_data, tx_wr, tx_clr, rx_ack,
        input  tx_busy, tx_overflow, rx_data, rx_valid, rx_overrun, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_wr, tx_clr, rx_ack,
        output tx_busy, tx_overflow, rx_data, rx_valid, rx_overrun, rx_frame_err
    );
endinterface

// File: rtl/gx4000_rs232_uart.sv
// 8N1 RS232 line engine: holding-register transmitter with CTS gating and a
// mid-bit sampling receiver with a single-byte buffer driving RTS.
module gx4000_rs232_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic                clk_sys,
    input  logic                reset,
    gx4000_rs232_uart_if.slave  bus,
    input  logic                rs232_cts,
    input  logic                rs232_rx,
    output logic                rs232_tx,
    output logic                rs232_rts
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // Bit 0 = rx, bit 1 = cts; both idle high so reset to 1
    logic [1:0] async_in;
    logic [1:0] sync_out;
    assign async_in = {rs232_cts, rs232_rx};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic out_reg;
            always_ff @(posedge clk_sys or posedge reset) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    out_reg  <= 1'b1;
                end else begin
                    meta_reg <= async_in[gi];
                    out_reg  <= meta_reg;
                end
            end
            assign sync_out[gi] = out_reg;
        end
    endgenerate

    logic rx_s;
    logic cts_s;
    assign rx_s  = sync_out[0];
    assign cts_s = sync_out[1];

    // ---------------- transmit holding register ----------------
    logic       tx_busy_reg;
    logic       tx_overflow_reg;
    logic [7:0] tx_hold_reg;
    logic       tx_load;
    logic       tx_take;

    assign tx_load = bus.tx_wr & ~tx_busy_reg;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tx_busy_reg     <= 1'b0;
            tx_overflow_reg <= 1'b0;
            tx_hold_reg     <= 8'h00;
        end else begin
            if (tx_load) begin
                tx_hold_reg <= bus.tx_data;
                tx_busy_reg <= 1'b1;
            end else if (tx_take) begin
                tx_busy_reg <= 1'b0;
            end
            if (bus.tx_wr & tx_busy_reg)
                tx_overflow_reg <= 1'b1;
            else if (bus.tx_clr)
                tx_overflow_reg <= 1'b0;
        end
    end

    // ---------------- transmit FSM ----------------
    state_t           tx_state_reg, tx_state_next;
    logic [CNT_W-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]       tx_bit_reg, tx_bit_next;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic             tx_line_reg, tx_line_next;
    logic             tx_cnt_last;

    assign tx_cnt_last = (tx_cnt_reg == CNT_LAST);
    // Frame boundary also counts as idle so back-to-back bytes need no gap
    assign tx_take = tx_busy_reg & cts_s &
                     ((tx_state_reg == ST_IDLE) | ((tx_state_reg == ST_STOP) & tx_cnt_last));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tx_state_reg <= ST_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= 3'd0;
            tx_shift_reg <= 8'h00;
            tx_line_reg  <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_line_reg  <= tx_line_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_last ? '0 : tx_cnt_reg + CNT_ONE;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        unique case (tx_state_reg)
            ST_IDLE: begin
                tx_cnt_next = '0;
                if (tx_take) begin
                    tx_state_next = ST_START;
                    tx_shift_next = tx_hold_reg;
                end
            end
            ST_START: if (tx_cnt_last) tx_state_next = ST_DATA;
            ST_DATA: begin
                if (tx_cnt_last) begin
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_bit_next   = tx_bit_reg + 3'd1;
                    if (tx_bit_reg == 3'd7) tx_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tx_take) begin
                    tx_state_next = ST_START;
                    tx_shift_next = tx_hold_reg;
                end else if (tx_cnt_last) begin
                    tx_state_next = ST_IDLE;
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_line_next = 1'b1;
        unique case (tx_state_reg)
            ST_START: tx_line_next = 1'b0;
            ST_DATA:  tx_line_next = tx_shift_reg[0];
            default:  tx_line_next = 1'b1;
        endcase
    end

    // ---------------- receive FSM ----------------
    state_t           rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]       rx_bit_reg, rx_bit_next;
    logic [7:0]       rx_shift_reg, rx_shift_next;
    logic             rx_cnt_last;
    logic             rx_done;

    assign rx_cnt_last = (rx_cnt_reg == CNT_LAST);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rx_state_reg <= ST_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'h00;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_last ? '0 : rx_cnt_reg + CNT_ONE;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        unique case (rx_state_reg)
            ST_IDLE: begin
                rx_cnt_next = '0;
                if (!rx_s) rx_state_next = ST_START;
            end
            ST_START: begin
                // Half-bit re-check rejects glitches and aligns to bit centres
                if (rx_cnt_reg == CNT_MID) begin
                    rx_cnt_next   = '0;
                    rx_state_next = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt_last) begin
                    rx_shift_next = {rx_s, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == 3'd7) rx_state_next = ST_STOP;
                end
            end
            ST_STOP: if (rx_cnt_last) rx_state_next = ST_IDLE;
            default: rx_state_next = ST_IDLE;
        endcase
    end

    // ---------------- receive buffer ----------------
    logic [7:0] rx_data_reg, rx_data_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       rx_overrun_reg, rx_overrun_next;
    logic       rx_frame_err_reg, rx_frame_err_next;
    logic       rts_reg;
    logic       rx_accept;
    logic       rx_consume;

    always_comb begin
        rx_done           = (rx_state_reg == ST_STOP) & rx_cnt_last;
        rx_accept         = rx_done & (~rx_valid_reg | bus.rx_ack);
        rx_consume        = bus.rx_ack & rx_valid_reg;
        rx_data_next      = rx_data_reg;
        rx_frame_err_next = rx_frame_err_reg;
        rx_valid_next     = rx_valid_reg;
        rx_overrun_next   = rx_overrun_reg;
        if (rx_accept) begin
            rx_data_next      = rx_shift_reg;
            rx_frame_err_next = ~rx_s;
            rx_valid_next     = 1'b1;
        end else if (rx_consume) begin
            rx_valid_next = 1'b0;
        end
        if (rx_done & ~rx_accept)
            rx_overrun_next = 1'b1;
        else if (rx_consume)
            rx_overrun_next = 1'b0;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rx_data_reg      <= 8'h00;
            rx_valid_reg     <= 1'b0;
            rx_overrun_reg   <= 1'b0;
            rx_frame_err_reg <= 1'b0;
            rts_reg          <= 1'b1;
        end else begin
            rx_data_reg      <= rx_data_next;
            rx_valid_reg     <= rx_valid_next;
            rx_overrun_reg   <= rx_overrun_next;
            rx_frame_err_reg <= rx_frame_err_next;
            rts_reg          <= ~rx_valid_next;
        end
    end

    assign bus.tx_busy      = tx_busy_reg;
    assign bus.tx_overflow  = tx_overflow_reg;
    assign bus.rx_data      = rx_data_reg;
    assign bus.rx_valid     = rx_valid_reg;
    assign bus.rx_overrun   = rx_overrun_reg;
    assign bus.rx_frame_err = rx_frame_err_reg;
    assign rs232_tx         = tx_line_reg;
    assign rs232_rts        = rts_reg;
endmodule

// File: tb/tb_gx4000_rs232_uart.sv
// Scoreboard bench: a CLKS_PER_BIT=4 instance driven directly and a
// CLKS_PER_BIT=16 instance looped back tx->rx for the reset-abort scenario.
module tb_gx4000_rs232_uart;
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic reset = 1'b0;
    logic cts4, rx4, tx4, rts4;
    logic cts16, tx16, rts16;

    gx4000_rs232_uart_if u_if4 ();
    gx4000_rs232_uart_if u_if16 ();

    gx4000_rs232_uart #(.CLKS_PER_BIT(4), .CNT_W(16)) dut4 (
        .clk_sys(clk_sys), .reset(reset), .bus(u_if4),
        .rs232_cts(cts4), .rs232_rx(rx4), .rs232_tx(tx4), .rs232_rts(rts4)
    );

    gx4000_rs232_uart #(.CLKS_PER_BIT(16), .CNT_W(16)) dut16 (
        .clk_sys(clk_sys), .reset(reset), .bus(u_if16),
        .rs232_cts(cts16), .rs232_rx(tx16), .rs232_tx(tx16), .rs232_rts(rts16)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] tx_exp[$];
    logic [8:0] rx_exp[$];   // {frame_err, data}

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic cpu_write(input bit sel, input logic [7:0] d, input bit clr);
        if (sel) begin
            u_if16.tx_data = d; u_if16.tx_wr = 1'b1; u_if16.tx_clr = clr;
        end else begin
            u_if4.tx_data = d; u_if4.tx_wr = 1'b1; u_if4.tx_clr = clr;
        end
        tick(1);
        u_if4.tx_wr = 1'b0; u_if4.tx_clr = 1'b0;
        u_if16.tx_wr = 1'b0; u_if16.tx_clr = 1'b0;
    endtask

    task automatic rx_ack_pulse(input bit sel);
        if (sel) u_if16.rx_ack = 1'b1; else u_if4.rx_ack = 1'b1;
        tick(1);
        u_if4.rx_ack = 1'b0; u_if16.rx_ack = 1'b0;
    endtask

    // Samples a whole frame on negedges, starting at the first low level
    task automatic capture(input bit sel, input int cpb, input int max_wait,
                           output logic [7:0] d, output logic stop, output bit exact,
                           output bit found, output int waited);
        logic line, first;
        d = 8'h00; stop = 1'b0; exact = 1'b1; found = 1'b0; waited = 0; first = 1'b0;
        @(negedge clk_sys);
        line = sel ? tx16 : tx4;
        while (line !== 1'b0 && waited < max_wait) begin
            @(negedge clk_sys);
            waited++;
            line = sel ? tx16 : tx4;
        end
        if (line !== 1'b0) return;
        found = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < cpb; c++) begin
                if (b != 0 || c != 0) begin
                    @(negedge clk_sys);
                    line = sel ? tx16 : tx4;
                end
                if (c == 0) first = line;
                else if (line !== first) exact = 1'b0;
                if (c == cpb / 2) begin
                    if (b == 0 && line !== 1'b0) exact = 1'b0;
                    if (b >= 1 && b <= 8) d[b-1] = line;
                    if (b == 9) stop = line;
                end
            end
        end
    endtask

    task automatic wait_rx(input bit sel, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_sys);
            if ((sel ? u_if16.rx_valid : u_if4.rx_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop);
        rx4 = 1'b0; tick(4);
        for (int i = 0; i < 8; i++) begin
            rx4 = d[i]; tick(4);
        end
        rx4 = stop; tick(4);
        rx4 = 1'b1;
    endtask

    task automatic check_tx_frame(input string name, input logic [7:0] d, input logic stop,
                                  input bit exact, input bit found);
        logic [7:0] exp;
        exp = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'hxx;
        vectors++;
        if (!found || d !== exp || stop !== 1'b1 || !exact) begin
            miscompares++;
            $display("FAIL %s: got data=%h stop=%b exact=%b found=%b, want data=%h stop=1 exact=1 found=1",
                     name, d, stop, exact, found, exp);
        end else
            $display("tx %s: frame %h ok", name, d);
    endtask

    task automatic test_reset();
        logic [14:0] st4, st16;
        reset = 1'b1;
        cts4 = 1'b1; cts16 = 1'b1; rx4 = 1'b1;
        u_if4.tx_data = 8'h00; u_if4.tx_wr = 1'b0; u_if4.tx_clr = 1'b0; u_if4.rx_ack = 1'b0;
        u_if16.tx_data = 8'h00; u_if16.tx_wr = 1'b0; u_if16.tx_clr = 1'b0; u_if16.rx_ack = 1'b0;
        tick(3);
        st4  = {tx4, u_if4.tx_busy, u_if4.tx_overflow, u_if4.rx_data, u_if4.rx_valid,
                u_if4.rx_overrun, u_if4.rx_frame_err, rts4};
        st16 = {tx16, u_if16.tx_busy, u_if16.tx_overflow, u_if16.rx_data, u_if16.rx_valid,
                u_if16.rx_overrun, u_if16.rx_frame_err, rts16};
        vectors++;
        if (st4 !== 15'b1_0_0_00000000_0_0_0_1) begin
            miscompares++; $display("FAIL reset4: got %b want %b", st4, 15'b100000000000001);
        end else $display("reset4: status %b ok", st4);
        vectors++;
        if (st16 !== 15'b1_0_0_00000000_0_0_0_1) begin
            miscompares++; $display("FAIL reset16: got %b want %b", st16, 15'b100000000000001);
        end else $display("reset16: status %b ok", st16);
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_tx_frame();
        logic [7:0] d; logic stop; bit exact, found; int waited; int busy_cnt;
        busy_cnt = 0;
        tx_exp.push_back(8'hA5);
        fork
            begin
                cpu_write(1'b0, 8'hA5, 1'b0);
                capture(1'b0, 4, 16, d, stop, exact, found, waited);
            end
            begin
                repeat (8) begin
                    @(negedge clk_sys);
                    if (u_if4.tx_busy === 1'b1) busy_cnt++;
                end
            end
        join
        check_tx_frame("frame_a5", d, stop, exact, found);
        vectors++;
        if (busy_cnt != 1) begin
            miscompares++; $display("FAIL busy_width: got %0d cycles want 1", busy_cnt);
        end else $display("tx busy_width: %0d cycle ok", busy_cnt);
        tick(2);
    endtask

    task automatic test_cts_overflow();
        logic [7:0] d; logic stop; bit exact, found; int waited; bit stuck;
        cts4 = 1'b0; tick(4);
        tx_exp.push_back(8'h3C);
        cpu_write(1'b0, 8'h3C, 1'b0);
        cpu_write(1'b0, 8'h11, 1'b0);
        vectors++;
        if (u_if4.tx_busy !== 1'b1 || u_if4.tx_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: got busy=%b ovf=%b want 1 1", u_if4.tx_busy, u_if4.tx_overflow);
        end else $display("tx ovf_set: ok");
        stuck = 1'b1;
        repeat (24) begin
            @(negedge clk_sys);
            if (tx4 !== 1'b1) stuck = 1'b0;
        end
        vectors++;
        if (!stuck) begin
            miscompares++; $display("FAIL cts_hold: got line activity want idle 1");
        end else $display("tx cts_hold: line idle ok");
        tick(1);
        u_if4.tx_clr = 1'b1; tick(1); u_if4.tx_clr = 1'b0;
        vectors++;
        if (u_if4.tx_overflow !== 1'b0) begin
            miscompares++; $display("FAIL ovf_clr: got %b want 0", u_if4.tx_overflow);
        end else $display("tx ovf_clr: ok");
        cpu_write(1'b0, 8'h22, 1'b1);
        vectors++;
        if (u_if4.tx_overflow !== 1'b1) begin
            miscompares++; $display("FAIL ovf_set_wins: got %b want 1", u_if4.tx_overflow);
        end else $display("tx ovf_set_wins: ok");
        cts4 = 1'b1;
        capture(1'b0, 4, 16, d, stop, exact, found, waited);
        check_tx_frame("frame_3c_after_cts", d, stop, exact, found);
        tick(1);
        u_if4.tx_clr = 1'b1; tick(1); u_if4.tx_clr = 1'b0;
        vectors++;
        if (u_if4.tx_overflow !== 1'b0 || u_if4.tx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_final: got ovf=%b busy=%b want 0 0", u_if4.tx_overflow, u_if4.tx_busy);
        end else $display("tx ovf_final: ok");
        tick(2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2; logic s1, s2; bit e1, e2, f1, f2; int w1, w2;
        tx_exp.push_back(8'h5A);
        tx_exp.push_back(8'hC3);
        fork
            begin
                cpu_write(1'b0, 8'h5A, 1'b0);
                tick(8);
                cpu_write(1'b0, 8'hC3, 1'b0);
            end
            begin
                capture(1'b0, 4, 16, d1, s1, e1, f1, w1);
                capture(1'b0, 4, 16, d2, s2, e2, f2, w2);
            end
        join
        check_tx_frame("b2b_first", d1, s1, e1, f1);
        check_tx_frame("b2b_second", d2, s2, e2, f2);
        vectors++;
        if (w2 >= 4) begin
            miscompares++; $display("FAIL b2b_gap: got %0d idle cycles want <4", w2);
        end else $display("tx b2b_gap: %0d idle cycles ok", w2);
        tick(2);
    endtask

    task automatic check_rx(input string name, input bit sel);
        logic [8:0] exp, got;
        exp = (rx_exp.size() > 0) ? rx_exp.pop_front() : 9'hxxx;
        got = sel ? {u_if16.rx_frame_err, u_if16.rx_data} : {u_if4.rx_frame_err, u_if4.rx_data};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got ferr/data=%h want %h", name, got, exp);
        end else $display("rx %s: ferr/data=%h ok", name, got);
    endtask

    task automatic test_rx_basic();
        bit ok;
        rx_exp.push_back({1'b0, 8'h5A});
        rx_send(8'h5A, 1'b1);
        wait_rx(1'b0, 12, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL rx_5a_valid: got rx_valid=0 want 1");
        end
        check_rx("rx_5a", 1'b0);
        vectors++;
        if (rts4 !== 1'b0) begin
            miscompares++; $display("FAIL rts_full: got %b want 0", rts4);
        end else $display("rx rts_full: ok");
        tick(1);
        rx_ack_pulse(1'b0);
        vectors++;
        if (u_if4.rx_valid !== 1'b0 || rts4 !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_ack: got valid=%b rts=%b want 0 1", u_if4.rx_valid, rts4);
        end else $display("rx rx_ack: ok");
        tick(2);
    endtask

    task automatic test_rx_glitch_frame_err();
        bit ok;
        rx4 = 1'b0; tick(1); rx4 = 1'b1;
        tick(16);
        vectors++;
        if (u_if4.rx_valid !== 1'b0) begin
            miscompares++; $display("FAIL glitch: got rx_valid=%b want 0", u_if4.rx_valid);
        end else $display("rx glitch: rejected ok");
        rx_exp.push_back({1'b1, 8'h81});
        rx_send(8'h81, 1'b0);
        wait_rx(1'b0, 12, ok);
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL rx_81_valid: got rx_valid=0 want 1");
        end
        check_rx("rx_81_frame_err", 1'b0);
        tick(1);
        rx_ack_pulse(1'b0);
        tick(16);
    endtask

    task automatic test_rx_overrun();
        bit ok;
        rx_exp.push_back({1'b0, 8'h12});
        rx_send(8'h12, 1'b1);
        wait_rx(1'b0, 12, ok);
        tick(1);
        rx_send(8'h34, 1'b1);
        tick(4);
        vectors++;
        if (u_if4.rx_overrun !== 1'b1 || u_if4.rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got ovr=%b valid=%b want 1 1", u_if4.rx_overrun, u_if4.rx_valid);
        end else $display("rx overrun_set: ok");
        check_rx("overrun_old_kept", 1'b0);
        rx_ack_pulse(1'b0);
        vectors++;
        if (u_if4.rx_overrun !== 1'b0 || u_if4.rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_ack: got ovr=%b valid=%b want 0 0", u_if4.rx_overrun, u_if4.rx_valid);
        end else $display("rx overrun_ack: ok");
        tick(2);
        // Second pass: ack lands in the completion cycle of the next byte
        rx_exp.push_back({1'b0, 8'h12});
        rx_send(8'h12, 1'b1);
        wait_rx(1'b0, 12, ok);
        check_rx("pre_coincide", 1'b0);
        tick(1);
        rx_exp.push_back({1'b0, 8'h34});
        rx_send(8'h34, 1'b1);
        rx_ack_pulse(1'b0);
        tick(1);
        check_rx("ack_coincide", 1'b0);
        vectors++;
        if (u_if4.rx_overrun !== 1'b0 || u_if4.rx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL coincide_status: got ovr=%b valid=%b want 0 1", u_if4.rx_overrun, u_if4.rx_valid);
        end else $display("rx coincide_status: ok");
        rx_ack_pulse(1'b0);
        tick(2);
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d; logic stop; bit exact, found, ok; int waited;
        logic [14:0] st4, st16;
        // Leave an unread byte in the small instance so reset has status to clear
        rx_exp.push_back({1'b0, 8'h77});
        rx_send(8'h77, 1'b1);
        wait_rx(1'b0, 12, ok);
        check_rx("pre_reset_77", 1'b0);
        tick(1);
        cpu_write(1'b1, 8'h96, 1'b0);
        waited = 0;
        @(negedge clk_sys);
        while (tx16 !== 1'b0 && waited < 32) begin
            @(negedge clk_sys);
            waited++;
        end
        repeat ((1 + 3) * 16 + 8) @(negedge clk_sys);
        reset = 1'b1;
        #1;
        st4  = {tx4, u_if4.tx_busy, u_if4.tx_overflow, u_if4.rx_data, u_if4.rx_valid,
                u_if4.rx_overrun, u_if4.rx_frame_err, rts4};
        st16 = {tx16, u_if16.tx_busy, u_if16.tx_overflow, u_if16.rx_data, u_if16.rx_valid,
                u_if16.rx_overrun, u_if16.rx_frame_err, rts16};
        vectors++;
        if (st16 !== 15'b100000000000001) begin
            miscompares++; $display("FAIL midframe_reset16: got %b want %b", st16, 15'b100000000000001);
        end else $display("reset midframe16: status %b ok", st16);
        vectors++;
        if (st4 !== 15'b100000000000001) begin
            miscompares++; $display("FAIL midframe_reset4: got %b want %b", st4, 15'b100000000000001);
        end else $display("reset midframe4: status %b ok", st4);
        tick(2);
        reset = 1'b0;
        tick(4);
        tx_exp.push_back(8'hFF);
        rx_exp.push_back({1'b0, 8'hFF});
        fork
            cpu_write(1'b1, 8'hFF, 1'b0);
            capture(1'b1, 16, 32, d, stop, exact, found, waited);
        join
        check_tx_frame("loop_ff_tx", d, stop, exact, found);
        wait_rx(1'b1, 40, ok);
        vectors++;
        if (!ok || u_if16.rx_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_ff_valid: got valid=%b ovr=%b want 1 0", ok, u_if16.rx_overrun);
        end
        check_rx("loop_ff_rx", 1'b1);
        tick(1);
        rx_ack_pulse(1'b1);
    endtask

    initial begin
        #1;
        test_reset();
        test_tx_frame();
        test_cts_overflow();
        test_back_to_back();
        test_rx_basic();
        test_rx_glitch_frame_err();
        test_rx_overrun();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
